acc_uart_tx: RTL
================

# acc_uart_tx

Serial output stage for the accumulator CPU. It sits directly downstream of the CPU's 8-bit output bus, which is the value the top-level wrapper drives onto `uo_out`. Whenever that value changes, or on explicit request, it transmits the value as one 8N1 UART frame on a single pin. Intermediate values that appear while a frame is in flight are collapsed: only the latest value is sent next. This lets a host observe accumulator traffic over one wire.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range 2..65535. The counter width is derived from it.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous, active-high. The wrapper drives it as `~rst_n`.
- `acc_in`  input  8  CPU output byte (accumulator), sampled every cycle.
- `auto_en`  input  1  1 = send automatically on a change of `acc_in`.
- `force_send`  input  1  single-cycle pulse requesting a frame of the current `acc_in`.
- `tx`  output  1  UART line; idle high.
- `busy`  output  1  high while a frame is in flight (START through STOP).
- `frame_count`  output  8  number of completed frames; wraps modulo 256.

## Operation

- Registers:
  - `last_sent[7:0]`: the value of the most recently started frame.
  - `shift[7:0]`: transmit data.
  - `bit_cnt[2:0]`: data-bit index.
  - `baud_cnt`: cycles elapsed within the current bit.
  - `force_pend`: a pending force request.
- Reset values: `tx`=1, `busy`=0, `frame_count`=0, `last_sent`=0x00, `force_pend`=0, state=IDLE.
- `force_pend` is set by `force_send`=1 in any state. It is cleared when a frame starts.
- Trigger condition, evaluated only in IDLE:
  - `force_send` is 1, or `force_pend` is 1, or
  - `auto_en` is 1 and `acc_in` != `last_sent`.
- On a trigger in IDLE:
  - `shift` and `last_sent` are loaded from the current `acc_in`.
  - `force_pend` is cleared and the state goes to START.
- FSM:
  - IDLE: `tx`=1.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first. Each bit is held for `CLKS_PER_BIT` cycles; `shift` shifts right after each bit.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
  - Then back to IDLE.
- `frame_count` increments on the last cycle of STOP. 0xFF wraps to 0x00.
- Changes of `acc_in` while busy are not queued. The IDLE comparison against `last_sent` picks up the value present at that moment. If `acc_in` returned to `last_sent` while busy, no frame is sent.
- `auto_en`=0 suppresses change-triggered frames only; forced frames are still sent.
- `tx` and `busy` are driven directly from registers, with no combinational path from the inputs.

## Timing

- Trigger seen in IDLE on edge t:
  - `tx` goes 0 and `busy` goes 1 after edge t, i.e. the start bit begins one cycle later.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles with `busy`=1.
  - Data bit i occupies cycles [(1+i)·`CLKS_PER_BIT`, (2+i)·`CLKS_PER_BIT`) after the start edge.
- After STOP, the block spends exactly one IDLE cycle (`tx`=1, `busy`=0) before it can start the next frame.
  - Back-to-back frame period = 10×`CLKS_PER_BIT`+1 cycles.
- `force_send` asserted in the same cycle as a change trigger produces one frame, not two.
- `force_send` asserted during a frame produces exactly one additional frame after it, even if `acc_in` is unchanged.
- `rst` mid-frame: on the next edge the frame is aborted.
  - All registers take their reset values, so `tx`=1 and `busy`=0.
  - `frame_count` is not incremented for the aborted frame.
- After reset with `auto_en`=1 and `acc_in`≠0x00, the first frame starts one cycle after `rst` deasserts.

## Test plan

With `CLKS_PER_BIT`=4 (frame = 40 cycles):

1. Reset, `auto_en`=1, `acc_in`=0x00 held → `tx` stays 1, `busy`=0 and `frame_count`=0 for 100 cycles.
2. `acc_in` steps 0x00→0xA5 → start bit one cycle later. Bits decode LSB-first as 1,0,1,0,0,1,0,1, then a stop bit. `busy` is high for 40 cycles and `frame_count`=1.
3. During the 0xA5 frame, `acc_in` goes 0x01→0x02→0x3C → exactly one follow-up frame carrying 0x3C, starting 41 cycles after the first start. `frame_count`=2.
4. `auto_en`=0, `acc_in`=0x77, `force_send` pulsed twice during one frame → exactly one extra frame of 0x77 after the current frame. No further frames follow.
5. Assert `rst` at cycle 15 of a frame → `tx`=1 and `busy`=0 on the next edge; `frame_count` unchanged at 0.
6. Force 256 frames → `frame_count` wraps to 0x00 after the 256th stop bit.

Source files
------------

// File: rtl/acc_uart_tx.sv
// 8N1 UART transmitter for the accumulator output byte: sends on change (auto_en)
// or on a force pulse, collapsing updates that arrive while a frame is in flight.
module acc_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] acc_in,
    input  logic       auto_en,
    input  logic       force_send,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frame_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       last_sent_q, last_sent_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic             force_pend_q, force_pend_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic             baud_last;
    logic             trigger;

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_count = frame_cnt_q;

    // State register; reset also aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            last_sent_q  <= 8'h00;
            bit_cnt_q    <= 3'd0;
            baud_q       <= '0;
            force_pend_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            last_sent_q  <= last_sent_d;
            bit_cnt_q    <= bit_cnt_d;
            baud_q       <= baud_d;
            force_pend_q <= force_pend_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);
    assign trigger   = force_send | force_pend_q | (auto_en & (acc_in != last_sent_q));

    // Next-state logic; tx_d/busy_d are the line values for the coming cycle
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        last_sent_d  = last_sent_q;
        bit_cnt_d    = bit_cnt_q;
        baud_d       = baud_q;
        force_pend_d = force_pend_q | force_send;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (trigger) begin
                    shift_d      = acc_in;
                    last_sent_d  = acc_in;
                    force_pend_d = 1'b0;
                    baud_d       = '0;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d      = '0;
                    tx_d        = 1'b1;
                    busy_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = S_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
